// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: controller states, default sizing
// constants and the wait-timer width helper.
package apb_pkg;

    localparam int unsigned APB_ADDR_W_DEF  = 32;
    localparam int unsigned APB_DATA_W_DEF  = 32;
    localparam int unsigned APB_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Counter width able to hold TIMEOUT; a disabled timeout still gets one bit.
    function automatic int unsigned timer_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase. Counts stalled cycles and
// flags the cycle in which the count reaches the programmed limit.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   count_inc;

    // Value the counter would hold after this stalled cycle.
    assign count_inc = {1'b0, count_q} + (WIDTH+1)'(1);

    // Limit of zero disables expiry; expiry coincides with the stall that reaches it.
    assign expired = enable && !clear && (limit != '0) && (count_inc == {1'b0, limit});

    // Next count: clear wins, otherwise saturating increment on stalled cycles.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts a command, runs SETUP/ACCESS on the
// bus, and returns a registered response, aborting stalled slaves on timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W_DEF,
    parameter int unsigned DATA_W  = APB_DATA_W_DEF,
    parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int unsigned     TW    = timer_width(TIMEOUT);
    localparam logic [TW-1:0]   LIMIT = TW'(TIMEOUT);

    apb_state_e        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    // SETUP always leads into ACCESS, so clearing there restarts the count.
    assign timer_clear = (state_q == SETUP);
    assign timer_en    = (state_q == ACCESS) && !pready;

    apb_wait_timer #(
        .WIDTH(TW)
    ) u_wait_timer (
        .clk    (pclk),
        .rst    (preset),
        .clear  (timer_clear),
        .enable (timer_en),
        .limit  (LIMIT),
        .expired(timer_expired)
    );

    // Next-state and registered-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready has priority over an expiry landing in the same cycle.
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if (timer_expired) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers checked against a transaction-level expectation.
module tb_apb_master;

    localparam int unsigned TO = 4;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [31:0] prdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Command left pending on cmd_valid while a response is back-pressured.
    logic        nxt_wr;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wdata;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .psel     (psel),
        .penable  (penable),
        .pready   (pready),
        .prdata   (prdata)
    );

    // One full transfer. waits = ACCESS cycles the slave holds pready low
    // before raising it; the outcome follows from the timeout rule alone.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] sdata, input int hold,
                           input bit pend);
        bit          exp_err;
        int          exp_acc;
        logic [31:0] exp_rd;
        int          cyc, nsel, nen, acc_idx, lat;
        bit          done;

        exp_err = (TO > 0) && (waits >= int'(TO));
        exp_acc = exp_err ? int'(TO) : waits + 1;
        exp_rd  = (exp_err || wr) ? 32'h0 : sdata;
        nsel = 0; nen = 0; acc_idx = 0; lat = -1; done = 1'b0;

        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1; rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b expected 1", cmd_ready); end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom_range(1));
        cyc = 1;
        while (!done && cyc < 60) begin
            if (cyc == 1) begin
                n_checks++;
                if ({psel, penable} !== 2'b10) begin n_fail++; $display("FAIL setup_phase: psel/penable got %b expected 10", {psel, penable}); end
            end
            n_checks++;
            if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: cycle %0d got %b expected 0", cyc, cmd_ready); end
            if (psel === 1'b1) begin
                nsel++;
                if (penable === 1'b1) nen++;
                n_checks++;
                if ({paddr, pwrite, pwdata} !== {addr, wr, wdata}) begin
                    n_fail++;
                    $display("FAIL bus_stable: paddr/pwrite/pwdata got %h/%b/%h expected %h/%b/%h", paddr, pwrite, pwdata, addr, wr, wdata);
                end
            end
            if (rsp_valid === 1'b1) begin
                lat  = cyc;
                done = 1'b1;
            end else begin
                if (psel === 1'b1 && penable === 1'b1) begin
                    acc_idx++;
                    pready = (acc_idx > waits);
                    prdata = pready ? sdata : $urandom;
                end else begin
                    pready = 1'($urandom_range(1));
                    prdata = $urandom;
                end
                @(negedge pclk);
                cyc++;
            end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", cyc); end
        n_checks++;
        if (lat !== 2 + exp_acc) begin n_fail++; $display("FAIL latency: got %0d expected %0d", lat, 2 + exp_acc); end
        n_checks++;
        if (nsel !== 1 + exp_acc) begin n_fail++; $display("FAIL psel_cycles: got %0d expected %0d", nsel, 1 + exp_acc); end
        n_checks++;
        if (nen !== exp_acc) begin n_fail++; $display("FAIL penable_cycles: got %0d expected %0d", nen, exp_acc); end
        n_checks++;
        if (rsp_err !== exp_err) begin n_fail++; $display("FAIL rsp_err: got %b expected %b", rsp_err, exp_err); end
        n_checks++;
        if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, exp_rd); end
        n_checks++;
        if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL resp_bus_idle: psel/penable got %b expected 00", {psel, penable}); end

        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                cmd_valid = 1'b1; cmd_write = nxt_wr; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
            end
            pready = 1'($urandom_range(1));
            prdata = $urandom;
            @(negedge pclk);
            n_checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel} !== {1'b1, exp_err, exp_rd, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rsp_hold: valid/err/rdata/cmd_ready/psel got %b/%b/%h/%b/%b expected 1/%b/%h/0/0",
                         rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel, exp_err, exp_rd);
            end
            n_checks++;
            if (paddr !== addr) begin n_fail++; $display("FAIL hold_paddr: got %h expected %h", paddr, addr); end
        end

        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
            n_fail++;
            $display("FAIL rsp_done: rsp_valid/cmd_ready/psel got %b expected 010", {rsp_valid, cmd_ready, psel});
        end
        n_checks++;
        if ({paddr, pwrite, pwdata} !== {addr, wr, wdata}) begin
            n_fail++;
            $display("FAIL bus_retain: paddr/pwrite/pwdata got %h/%b/%h expected %h/%b/%h", paddr, pwrite, pwdata, addr, wr, wdata);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
        repeat (3) @(negedge pclk);
        n_checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: psel/penable/pwrite/rsp_valid/rsp_err got %b expected 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
        end
        n_checks++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data: paddr/pwdata/rsp_rdata got %h/%h/%h expected 0", paddr, pwdata, rsp_rdata);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_write_zero_wait();
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, 32'h20, 32'h0, 3, 32'h12345678, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h30, 32'h0, 1000, 32'hCAFEF00D, 1, 1'b0);
        run_txn(1'b1, 32'h34, 32'h55AA55AA, 1000, 32'h0, 0, 1'b0);
    endtask

    task automatic test_ready_at_limit();
        run_txn(1'b0, 32'h40, 32'h0, int'(TO) - 1, 32'hA5A5F00F, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        nxt_wr = 1'b0; nxt_addr = 32'h60; nxt_wdata = 32'h0;
        run_txn(1'b1, 32'h50, 32'h0BADF00D, 1, 32'h0, 5, 1'b1);
        run_txn(nxt_wr, nxt_addr, nxt_wdata, 0, 32'h77665544, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int guard;
        cmd_write = 1'b0; cmd_addr = 32'h70; cmd_wdata = 32'h0; cmd_valid = 1'b1; pready = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!(psel === 1'b1 && penable === 1'b1) && guard < 10) begin
            @(negedge pclk);
            guard++;
        end
        n_checks++;
        if (!(psel === 1'b1 && penable === 1'b1)) begin n_fail++; $display("FAIL reach_access: psel/penable got %b expected 11", {psel, penable}); end
        pready = 1'b0;
        preset = 1'b1;
        @(negedge pclk);
        n_checks++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL mid_reset: psel/penable/rsp_valid/cmd_ready got %b expected 0001", {psel, penable, rsp_valid, cmd_ready});
        end
        n_checks++;
        if (paddr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_paddr: got %h expected 0", paddr); end
        preset = 1'b0;
        pready = 1'b1;
        repeat (2) @(negedge pclk);
        n_checks++;
        if ({rsp_valid, psel} !== 2'b00) begin n_fail++; $display("FAIL no_stale_rsp: rsp_valid/psel got %b expected 00", {rsp_valid, psel}); end
        run_txn(1'b0, 32'h74, 32'h0, 2, 32'h31415926, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom_range(1)), $urandom, $urandom, int'($urandom_range(0, 6)),
                    $urandom, int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout();
        test_ready_at_limit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
